// File: rtl/tc_wb_drain.sv
// Drains one row of PE accumulators through a small FWFT FIFO onto an addressed write stream.
// Optional stall counter output is enabled with `define TC_WB_STALL_CNT_EN.
module tc_wb_drain #(
   parameter int unsigned N          = 4,
   parameter int unsigned NPE        = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned AW         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   output logic              wben,
   output logic [NPE-1:0]    out_ready,
   input  logic [32*NPE-1:0] out_sum_i,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       m_data,
   output logic [AW-1:0]     m_addr,
   output logic              m_last,
   output logic              busy,
   output logic              done
`ifdef TC_WB_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int unsigned NW   = NPE * N;
   localparam int unsigned KW   = $clog2(NW);
   localparam int unsigned LOGN = $clog2(N);
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = PW + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StFlush, StDone} state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [AW-1:0]   base_q, base_d;
   logic            inflight_q, inflight_d;
   logic [KW-1:0]   infl_k_q, infl_k_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     mem_data_q [FIFO_DEPTH];
   logic [KW-1:0]   mem_k_q    [FIFO_DEPTH];

   logic            can_issue, issue, push, pop;
   logic [KW-1:0]   issue_p, infl_p;
   logic [31:0]     push_data;

   // Word index k = p*N + w, so the PE index is simply the upper bits of k.
   assign issue_p   = k_q >> LOGN;
   assign infl_p    = infl_k_q >> LOGN;
   assign push_data = out_sum_i[32*int'(infl_p) +: 32];
   assign can_issue = (32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH;
   assign issue     = (state_q == StIssue) && can_issue;
   assign push      = inflight_q;
   assign m_valid   = (count_q != '0);
   assign pop       = m_valid && m_ready;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      base_d     = base_q;
      inflight_d = issue;
      infl_k_d   = issue ? k_q : infl_k_q;
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StIssue;
               base_d  = base_addr;
               k_d     = '0;
            end
         end
         StIssue: begin
            if (issue) begin
               k_d = k_q + 1'b1;
               if (k_q == KW'(NW - 1)) state_d = StFlush;
            end
         end
         StFlush: begin
            if (!inflight_q && (count_d == '0)) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q == StIssue) || (state_q == StFlush);
      done      = (state_q == StDone);
      wben      = (state_q == StIssue) || ((state_q == StFlush) && inflight_q);
      out_ready = issue ? (NPE'(1) << issue_p) : '0;
      m_data    = m_valid ? mem_data_q[rd_ptr_q] : '0;
      m_addr    = m_valid ? base_q + (AW'(mem_k_q[rd_ptr_q]) << 2) : '0;
      m_last    = m_valid && (mem_k_q[rd_ptr_q] == KW'(NW - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         k_q        <= '0;
         base_q     <= '0;
         inflight_q <= 1'b0;
         infl_k_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         base_q     <= base_d;
         inflight_q <= inflight_d;
         infl_k_q   <= infl_k_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: count_q alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= push_data;
         mem_k_q[wr_ptr_q]    <= infl_k_q;
      end
   end

`ifdef TC_WB_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == StIdle) && start) begin
         stall_d = '0;
      end else if (busy && ((m_valid && !m_ready) || ((state_q == StIssue) && !can_issue))
                   && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) stall_q <= '0;
      else      stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tc_wb_drain.sv
// Directed bench for tc_wb_drain with a 4x4 PE row model returning 0xA000_0000 + 16p + w.
module tb_tc_wb_drain;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [31:0]  base_addr = '0;
   logic         wben;
   logic [3:0]   out_ready;
   logic [127:0] out_sum_i;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [31:0]  m_data;
   logic [31:0]  m_addr;
   logic         m_last;
   logic         busy;
   logic         done;
`ifdef TC_WB_STALL_CNT_EN
   logic [31:0]  stall_cycles;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   tc_wb_drain #(.N(4), .NPE(4), .FIFO_DEPTH(4), .AW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .wben      (wben),
      .out_ready (out_ready),
      .out_sum_i (out_sum_i),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_addr    (m_addr),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
`ifdef TC_WB_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   // PE row model: registered out_sum, per-PE read pointer.
   logic [31:0] pe_sum [4];
   logic [1:0]  pe_ptr [4];

   for (genvar p = 0; p < 4; p++) begin : g_pe
      assign out_sum_i[32*p +: 32] = pe_sum[p];
      always @(posedge clk) begin
         if (!rst) begin
            pe_ptr[p] <= '0;
            pe_sum[p] <= '0;
         end else if (out_ready[p]) begin
            pe_sum[p] <= 32'hA000_0000 + 32'(16 * p) + 32'(pe_ptr[p]);
            pe_ptr[p] <= pe_ptr[p] + 2'd1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         1:       return !(c >= 3 && c <= 10);
         2:       return (c % 2) == 0;
         5:       return !(c >= 3 && c <= 12);
         default: return 1'b1;
      endcase
   endfunction

   // Modes: 0 free-run, 1 stall 3..10, 2 toggling ready, 3 second start at c=5,
   // 4 reset at c=8, 5 stall 3..12.
   task automatic run_drain(input logic [31:0] base, input int mode);
      int          n = 0;
      int          done_cyc = -1;
      int          issues_early = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_d = '0, prev_a = '0;
      logic [31:0] exp_d;
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = base;
      m_ready   = ready_for(mode, 0);
      for (int c = 0; c < 200; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
            start     = (mode == 3) && (c == 5);
            base_addr = ((mode == 3) && (c == 5)) ? 32'h0000_5000 : base;
            m_ready   = ready_for(mode, c);
            if (mode == 4 && c == 8) rst = 1'b0;
            if (mode == 4 && c == 9) rst = 1'b1;
         end
         @(negedge clk);
         if (mode == 4 && c == 9) begin
            check_eq("rst_wben", 32'(wben), 0);
            check_eq("rst_out_ready", 32'(out_ready), 0);
            check_eq("rst_m_valid", 32'(m_valid), 0);
            check_eq("rst_m_data", m_data, 0);
            check_eq("rst_m_addr", m_addr, 0);
            check_eq("rst_m_last", 32'(m_last), 0);
            check_eq("rst_busy", 32'(busy), 0);
         end
         if (mode == 4 && c > 9) begin
            check_eq("rst_no_done", 32'(done), 0);
            if (c == 14) return;
            continue;
         end
         if (c == 1) begin
            check_eq("busy_after_start", 32'(busy), 1);
            check_eq("first_out_ready", 32'(out_ready), 32'h1);
         end
         if (mode == 0 && c == 2) check_eq("m_valid_c2", 32'(m_valid), 0);
         if (mode == 0 && c == 3) check_eq("m_valid_c3", 32'(m_valid), 1);
         if (|out_ready && c <= 10) issues_early++;
         if (prev_stall) begin
            check_eq("hold_valid", 32'(m_valid), 1);
            check_eq("hold_data", m_data, prev_d);
            check_eq("hold_addr", m_addr, prev_a);
         end
         if (m_valid && m_ready) begin
            exp_d = 32'hA000_0000 + 32'(16 * (n / 4)) + 32'(n % 4);
            check_eq("word_data", m_data, exp_d);
            check_eq("word_addr", m_addr, base + 32'(4 * n));
            check_eq("word_last", 32'(m_last), 32'(n == 15));
            n++;
         end
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
         prev_a     = m_addr;
         if (done) begin
            done_cyc = c;
            check_eq("busy_at_done", 32'(busy), 0);
            break;
         end
      end
      check_eq("done_seen", 32'(done_cyc >= 0), 1);
      check_eq("word_count", 32'(n), 16);
      if (mode == 0 || mode == 3) check_eq("done_cycle", 32'(done_cyc), 19);
      if (mode == 1) check_eq("issues_before_c10", 32'(issues_early), 4);
`ifdef TC_WB_STALL_CNT_EN
      if (mode == 5) check_eq("stall_ge10", 32'(stall_cycles >= 32'd10), 1);
`endif
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("reset_wben", 32'(wben), 0);
      check_eq("reset_out_ready", 32'(out_ready), 0);
      check_eq("reset_m_valid", 32'(m_valid), 0);
      check_eq("reset_m_data", m_data, 0);
      check_eq("reset_m_addr", m_addr, 0);
      check_eq("reset_busy", 32'(busy), 0);
      check_eq("reset_done", 32'(done), 0);
`ifdef TC_WB_STALL_CNT_EN
      check_eq("reset_stall", stall_cycles, 0);
`endif
      run_drain(32'h0000_1000, 0);
      run_drain(32'h0000_1000, 1);
      run_drain(32'h0000_1000, 2);
      run_drain(32'h0000_1000, 3);
      run_drain(32'h0000_1000, 4);
      run_drain(32'h0000_2000, 0);
      run_drain(32'hFFFF_FFF8, 5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
